alu_seq: RTL and testbench

- Parametrised, registered successor to the execute-stage combinational ALU.
- Same command encoding and status layout, generalised to WIDTH bits.
- Adds an iterative shift-add unsigned multiply, a valid/ready handshake on both sides, and registered result and flags.
- Sits between the register-read and writeback stages; stalls upstream while a multiply is in flight.

---
 rtl/alu_seq.sv | 119 +++++++++++
 tb/tb_alu_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete at the accept edge; MUL iterates one shift-add step per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       cmd,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       status_out
);

  localparam logic [3:0] C_MOV = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_ADC = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0100;
  localparam logic [3:0] C_SBC = 4'b0101;
  localparam logic [3:0] C_AND = 4'b0110;
  localparam logic [3:0] C_ORR = 4'b0111;
  localparam logic [3:0] C_EOR = 4'b1000;
  localparam logic [3:0] C_MVN = 4'b1001;
  localparam logic [3:0] C_MUL = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;
  logic [WIDTH:0]   a, b, res;
  logic             is_add, is_sub, c_f, v_f, accept, is_mul;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (cmd == C_MUL);
  assign a        = {1'b0, src1};
  assign b        = {1'b0, src2};

  // Single-cycle datapath; illegal codes fall to res=0 so Z alone is set.
  always_comb begin
    res    = '0;
    is_add = 1'b0;
    is_sub = 1'b0;
    case (cmd)
      C_MOV: res = b;
      C_MVN: res = {1'b0, ~src2};
      C_ADD: begin res = a + b; is_add = 1'b1; end
      C_ADC: begin res = a + b + {{WIDTH{1'b0}}, carry}; is_add = 1'b1; end
      C_SUB: begin res = a - b; is_sub = 1'b1; end
      C_SBC: begin res = a - b - {{WIDTH{1'b0}}, ~carry}; is_sub = 1'b1; end
      C_AND: res = a & b;
      C_ORR: res = a | b;
      C_EOR: res = a ^ b;
      default: res = '0;
    endcase
    c_f = (is_add || is_sub) && res[WIDTH];
    v_f = (is_add && (src1[WIDTH-1] == src2[WIDTH-1]) && (res[WIDTH-1] != src1[WIDTH-1])) ||
          (is_sub && (src1[WIDTH-1] != src2[WIDTH-1]) && (res[WIDTH-1] != src1[WIDTH-1]));
  end

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out        <= '0;
      status_out <= '0;
      out_valid  <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_mul) begin
              mcand     <= src1;
              mplier    <= src2;
              acc       <= '0;
              cnt       <= CNT_W'(WIDTH-1);
              out_valid <= 1'b0;
              state     <= BUSY;
            end else begin
              out        <= res[WIDTH-1:0];
              status_out <= {v_f, res[WIDTH-1], c_f, (res[WIDTH-1:0] == '0)};
              out_valid  <= 1'b1;
              state      <= DONE;
            end
          end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            out        <= acc_nxt;
            status_out <= {1'b0, acc_nxt[WIDTH-1], 1'b0, (acc_nxt == '0)};
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_seq;
  logic        clk = 1'b0, rst;
  logic        in_valid, in_ready, carry, out_valid, out_ready;
  logic [31:0] src1, src2, out;
  logic [3:0]  cmd, status_out;
  int          checks = 0, errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .cmd(cmd), .carry(carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .status_out(status_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Presents one command for a single edge; caller samples 1ns after that edge.
  task automatic op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input logic cy);
    cmd = c; src1 = x; src2 = y; carry = cy; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic res(input string tag, input logic [31:0] eo, input logic [3:0] es);
    chk({tag, "_out"}, 64'(out), 64'(eo));
    chk({tag, "_st"}, 64'(status_out), 64'(es));
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int n;
    bit early;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; cmd = '0; carry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_st", 64'(status_out), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    rst = 1'b0;

    op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0);  res("add_ovf", 32'h8000_0000, 4'b1100);
    op(4'b0100, 32'd5, 32'd5, 1'b0);          res("sub_eq", 32'h0, 4'b0001);
    op(4'b0100, 32'd3, 32'd5, 1'b0);          res("sub_brw", 32'hFFFF_FFFE, 4'b0110);
    op(4'b0101, 32'd5, 32'd5, 1'b0);          res("sbc", 32'hFFFF_FFFF, 4'b0110);
    op(4'b1001, 32'h0, 32'h0000_00FF, 1'b0);  res("mvn", 32'hFFFF_FF00, 4'b0100);
    op(4'b1000, 32'hF0F0, 32'hFF00, 1'b0);    res("eor", 32'h0000_0FF0, 4'b0000);

    // MUL with operands scrambled after accept to prove they were latched.
    op(4'b1010, 32'd7, 32'd6, 1'b0);
    src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678; cmd = 4'b0010;
    n = 0; early = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) early = 1'b1;
      @(posedge clk); #1; n++;
    end
    chk("mul_lat", 64'(n), 64'd32);
    chk("mul_busy_rdy", 64'(early), 64'd0);
    res("mul", 32'd42, 4'b0000);

    op(4'b1010, 32'h1_0000, 32'h1_0000, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("mul_z_lat", 64'(n), 64'd32);
    res("mul_z", 32'h0, 4'b0001);

    // Backpressure: drain to IDLE, then hold ORR result for 5 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    op(4'b0111, 32'hF0, 32'h0F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      res("bp_hold", 32'hFF, 4'b0000);
      chk("bp_rdy", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    cmd = 4'b0010; src1 = 32'd1; src2 = 32'd2; in_valid = 1'b1;
    #1;
    chk("bp_rel_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    res("bp_next", 32'd3, 4'b0000);

    // Reset mid-multiply.
    op(4'b1010, 32'd3, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_vld", 64'(out_valid), 64'd0);
    chk("mrst_rdy", 64'(in_ready), 64'd1);
    chk("mrst_out", 64'(out), 64'd0);
    chk("mrst_st", 64'(status_out), 64'd0);
    rst = 1'b0;
    op(4'b0010, 32'd1, 32'd1, 1'b0);          res("post_rst", 32'd2, 4'b0000);

    op(4'b1111, 32'h1234, 32'h5678, 1'b1);    res("illegal", 32'h0, 4'b0001);
    op(4'b0011, 32'hFFFF_FFFF, 32'h0, 1'b1);  res("adc", 32'h0, 4'b0011);

    @(posedge clk); #1;
    chk("idle_vld", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
